button_encoder: RTL

//  Front end for the game controller's INPUT_S: turns four raw, bouncy,

---
 rtl/button_encoder.sv | 119 +++++++++++
 1 files changed

// File: rtl/button_encoder.sv
// Four-button front end: synchronise, debounce and one-hot encode raw buttons
// into single {in_o, in_valid_o} press events, flagging chords separately.
module button_encoder #(
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [3:0] btn_i,
  input  logic       en_i,
  output logic [1:0] in_o,
  output logic       in_valid_o,
  output logic       chord_o,
  output logic [3:0] pressed_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  typedef enum logic {IDLE, HELD} state_e;

  logic [3:0] sync1_q, sync2_q;
  logic [3:0] pressed_q;
  state_e     state_q, state_d;
  logic [1:0] in_q, in_d;
  logic       in_valid_q, in_valid_d;
  logic       chord_q, chord_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Any cycle where the synchronised level matches the stable level restarts the count.
  for (genvar gi = 0; gi < 4; gi++) begin : g_db
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

    always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync2_q[gi] == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q[gi];
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end

    assign pressed_q[gi] = stable_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pressed_q != 4'b0000) state_d = HELD;
      HELD:    if (pressed_q == 4'b0000) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Events only fire on the first nonzero debounced cycle seen from IDLE.
  always_comb begin
    in_d       = in_q;
    in_valid_d = 1'b0;
    chord_d    = 1'b0;
    if (state_q == IDLE && pressed_q != 4'b0000 && en_i) begin
      case (pressed_q)
        4'b0001: begin in_d = 2'd0; in_valid_d = 1'b1; end
        4'b0010: begin in_d = 2'd1; in_valid_d = 1'b1; end
        4'b0100: begin in_d = 2'd2; in_valid_d = 1'b1; end
        4'b1000: begin in_d = 2'd3; in_valid_d = 1'b1; end
        default: chord_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      in_q       <= 2'd0;
      in_valid_q <= 1'b0;
      chord_q    <= 1'b0;
    end else begin
      in_q       <= in_d;
      in_valid_q <= in_valid_d;
      chord_q    <= chord_d;
    end
  end

  assign in_o       = in_q;
  assign in_valid_o = in_valid_q;
  assign chord_o    = chord_q;
  assign pressed_o  = pressed_q;

endmodule
